// File: rtl/i2c_req_arbiter_pkg.sv
// Shared types and helpers for the i2c request arbiter.
// FSM state encoding, frame length default, bit-period calculation.
package i2c_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  localparam int FRAME_PERIODS_DEFAULT = 22;

  // Cycles per SCL period minus one, truncated to the 10-bit counter.
  // speed==0 (and speed>clk_hz) fall to the slowest period, 1023.
  function automatic logic [9:0] bit_period(
    input logic [23:0] speed,
    input int unsigned clk_hz
  );
    logic [31:0] q;
    q = 32'hFFFF_FFFF;
    if (speed != '0) q = clk_hz / 32'(speed) - 32'd1;
    return q[9:0];
  endfunction

endpackage

// File: rtl/i2c_req_arbiter_rr_arbiter.sv
// Round-robin winner select: lowest index >= ptr (wrapping) with req set.
// Ports: req, ptr in; one-hot gnt and binary idx out.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx
);

  int          pos;
  logic [IW-1:0] p;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    p     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      p = IW'(pos);
      if (!found && req[p]) begin
        found  = 1'b1;
        gnt[p] = 1'b1;
        idx    = p;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin scheduler sharing one i2c_master between NUM_REQ requesters.
// Ports: clk, reset, speed, req/req_addr/req_data in; gnt, done, busy, pulse, addr2send, data2send out.
module i2c_req_arbiter
  import i2c_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int CLK_HZ        = 100_000_000,
  parameter int FRAME_PERIODS = FRAME_PERIODS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [23:0]            speed,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic                   pulse,
  output logic [6:0]             addr2send,
  output logic [7:0]             data2send
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [4:0] PER_LAST = 5'(FRAME_PERIODS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       ptr_q, idx_q, win_idx;
  logic [NUM_REQ-1:0]  win_gnt;
  logic [9:0]          p_q, cyc_q;
  logic [4:0]          per_q;
  logic                launch, term;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr (
    .req (req),
    .ptr (ptr_q),
    .gnt (win_gnt),
    .idx (win_idx)
  );

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    term    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          launch  = 1'b1;
          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        if (cyc_q == p_q && per_q == PER_LAST) begin
          term    = 1'b1;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt       <= '0;
      done      <= '0;
      pulse     <= 1'b0;
      addr2send <= '0;
      data2send <= '0;
      p_q       <= '0;
      cyc_q     <= '0;
      per_q     <= '0;
    end else begin
      state_q <= state_d;
      pulse   <= launch;
      done    <= term ? gnt : '0;
      if (launch) begin
        gnt       <= win_gnt;
        idx_q     <= win_idx;
        addr2send <= req_addr[7*win_idx +: 7];
        data2send <= req_data[8*win_idx +: 8];
        p_q       <= bit_period(speed, CLK_HZ);
        cyc_q     <= '0;
        per_q     <= '0;
      end else if (state_q == ARB_WAIT) begin
        if (cyc_q == p_q) begin
          cyc_q <= '0;
          per_q <= per_q + 5'd1;
        end else begin
          cyc_q <= cyc_q + 10'd1;
        end
      end
      if (state_q == ARB_DONE) begin
        gnt   <= '0;
        ptr_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign busy = (state_q != ARB_IDLE);

endmodule
